imem_boot_ctrl: RTL

- Boot and load controller that owns the writable instruction memory of the single-cycle MIPS core.
- After reset it zero-fills the memory, then accepts a program from an external loader over a valid/ready stream, writing words sequentially from address 0.
- It holds the CPU until the load completes, then serves combinational instruction fetch.
- In run mode a reload request restarts the whole clear/load sequence.

---
 rtl/imem_boot_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/imem_boot_ctrl.sv
// Instruction memory boot/load controller for the single-cycle MIPS core.
// Zero-fills memory, takes a program over a valid/ready stream, then serves fetch.
module imem_boot_ctrl #(
    parameter int ADDR_W        = 11,
    parameter bit CLEAR_ON_BOOT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_valid,
    input  logic [31:0]       ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic              reload_req,
    input  logic [31:0]       mem_address,
    output logic [31:0]       data_out,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              load_err
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam state_t BOOT_ST = CLEAR_ON_BOOT ? S_CLEAR : S_LOAD;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_ptr;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_word_count;
    logic                r_load_err;
    logic [31:0]         r_mem [DEPTH];

    logic                w_in_clear;
    logic                w_in_load;
    logic                w_in_run;
    logic                w_xfer;
    logic                w_we;
    logic [ADDR_W-1:0]   w_waddr;
    logic [31:0]         w_wdata;
    logic [ADDR_W-1:0]   w_raddr;
    logic                w_unused;

    assign w_in_clear = (r_state == S_CLEAR);
    assign w_in_load  = (r_state == S_LOAD);
    assign w_in_run   = (r_state == S_RUN);
    assign w_xfer     = w_in_load && ld_valid;

    assign ld_ready   = w_in_load;
    assign cpu_hold   = !w_in_run;
    assign load_done  = w_in_run;
    assign word_count = r_word_count;
    assign load_err   = r_load_err;

    // Sequencer: clear sweep, streamed load, run; reload restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= BOOT_ST;
            r_clr_ptr    <= '0;
            r_wr_ptr     <= '0;
            r_word_count <= '0;
            r_load_err   <= 1'b0;
        end else begin
            unique case (r_state)
                S_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + 1'b1;
                    if (r_clr_ptr == '1)
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_word_count != FULL_CNT)
                            r_word_count <= r_word_count + 1'b1;
                        if (ld_last) begin
                            r_state <= S_RUN;
                        end else if (r_wr_ptr == '1) begin
                            r_state    <= S_RUN;
                            r_load_err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (reload_req) begin
                        r_state      <= BOOT_ST;
                        r_clr_ptr    <= '0;
                        r_wr_ptr     <= '0;
                        r_word_count <= '0;
                        r_load_err   <= 1'b0;
                    end
                end
                default: r_state <= BOOT_ST;
            endcase
        end
    end

    // Single write port shared by the clear sweep and the loader.
    assign w_we    = !rst && (w_in_clear || w_xfer);
    assign w_waddr = w_in_clear ? r_clr_ptr : r_wr_ptr;
    assign w_wdata = w_in_clear ? 32'h0 : ld_data;

    // Memory array write; contents are never reset, only overwritten.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_waddr] <= w_wdata;
    end

    // Zero-latency fetch; NOP while the CPU is held.
    assign w_raddr  = mem_address[ADDR_W+1:2];
    assign data_out = w_in_run ? r_mem[w_raddr] : 32'h0;

    assign w_unused = ^{mem_address[31:ADDR_W+2], mem_address[1:0]};

endmodule
